// File: rtl/reg_file_fwd_if.sv
`default_nettype none
// ============================================================================
// reg_file_fwd_if : decoder read/write-back bundle for the ID operand unit
// Revision: 1.0
// ============================================================================
interface reg_file_fwd_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int CNT_WIDTH  = 32
);
   logic                  reg_read_en_1;
   logic [ADDR_WIDTH-1:0] reg_addr_1;
   logic                  reg_read_en_2;
   logic [ADDR_WIDTH-1:0] reg_addr_2;

   logic                  ex_load_flag;
   logic                  ex_write_en;
   logic [ADDR_WIDTH-1:0] ex_write_addr;
   logic [DATA_WIDTH-1:0] ex_write_data;

   logic                  mem_write_en;
   logic [ADDR_WIDTH-1:0] mem_write_addr;
   logic [DATA_WIDTH-1:0] mem_write_data;

   logic                  wb_write_en;
   logic [ADDR_WIDTH-1:0] wb_write_addr;
   logic [DATA_WIDTH-1:0] wb_write_data;

   logic [DATA_WIDTH-1:0] read_data_1;
   logic [DATA_WIDTH-1:0] read_data_2;
   logic                  stall_request;
   logic [CNT_WIDTH-1:0]  stall_count;

   modport master (
      output reg_read_en_1, reg_addr_1, reg_read_en_2, reg_addr_2,
      output ex_load_flag, ex_write_en, ex_write_addr, ex_write_data,
      output mem_write_en, mem_write_addr, mem_write_data,
      output wb_write_en, wb_write_addr, wb_write_data,
      input  read_data_1, read_data_2, stall_request, stall_count
   );

   modport slave (
      input  reg_read_en_1, reg_addr_1, reg_read_en_2, reg_addr_2,
      input  ex_load_flag, ex_write_en, ex_write_addr, ex_write_data,
      input  mem_write_en, mem_write_addr, mem_write_data,
      input  wb_write_en, wb_write_addr, wb_write_data,
      output read_data_1, read_data_2, stall_request, stall_count
   );
endinterface
`default_nettype wire

// File: rtl/reg_file_fwd.sv
`default_nettype none
// ============================================================================
// reg_file_fwd : 32-entry GPR file with EX>MEM>WB forwarding and load-use stall
// Revision: 1.0
// ============================================================================
module reg_file_fwd #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int REG_NUM    = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic          clk,
   input  logic          rst,
   reg_file_fwd_if.slave bus
);

   localparam int NUM_PORTS = 2;

   logic [DATA_WIDTH-1:0] regs_q [REG_NUM];
   logic [CNT_WIDTH-1:0]  stall_count_q;
   logic [CNT_WIDTH-1:0]  stall_count_d;

   logic [NUM_PORTS-1:0]  read_en;
   logic [ADDR_WIDTH-1:0] read_addr [NUM_PORTS];
   logic [DATA_WIDTH-1:0] read_data [NUM_PORTS];
   logic [NUM_PORTS-1:0]  load_hit;
   logic                  ex_load_valid;
   logic                  stall_request;

   assign read_en      = {bus.reg_read_en_2, bus.reg_read_en_1};
   assign read_addr[0] = bus.reg_addr_1;
   assign read_addr[1] = bus.reg_addr_2;

   // A load into $0 never produces a value anyone waits on.
   assign ex_load_valid = bus.ex_load_flag && bus.ex_write_en &&
                          (bus.ex_write_addr != '0);

   for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
      logic [DATA_WIDTH-1:0] array_val;

      always_comb begin
         array_val = '0;
         if (int'(read_addr[p]) < REG_NUM) begin
            array_val = regs_q[read_addr[p]];
         end
      end

      always_comb begin
         read_data[p] = '0;
         if (rst || !read_en[p] || (read_addr[p] == '0)) begin
            read_data[p] = '0;
         end else if (bus.ex_write_en && !bus.ex_load_flag &&
                      (bus.ex_write_addr == read_addr[p])) begin
            read_data[p] = bus.ex_write_data;
         end else if (bus.mem_write_en && (bus.mem_write_addr == read_addr[p])) begin
            read_data[p] = bus.mem_write_data;
         end else if (bus.wb_write_en && (bus.wb_write_addr == read_addr[p])) begin
            read_data[p] = bus.wb_write_data;
         end else begin
            read_data[p] = array_val;
         end
      end

      assign load_hit[p] = read_en[p] && (read_addr[p] == bus.ex_write_addr);
   end

   assign stall_request = !rst && ex_load_valid && (|load_hit);

   always_comb begin
      stall_count_d = stall_count_q;
      if (stall_request && (stall_count_q != {CNT_WIDTH{1'b1}})) begin
         stall_count_d = stall_count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < REG_NUM; i++) begin
            regs_q[i] <= '0;
         end
         stall_count_q <= '0;
      end else begin
         if (bus.wb_write_en && (bus.wb_write_addr != '0) &&
             (int'(bus.wb_write_addr) < REG_NUM)) begin
            regs_q[bus.wb_write_addr] <= bus.wb_write_data;
         end
         stall_count_q <= stall_count_d;
      end
   end

   assign bus.read_data_1   = read_data[0];
   assign bus.read_data_2   = read_data[1];
   assign bus.stall_request = stall_request;
   assign bus.stall_count   = stall_count_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_file_fwd.sv
`default_nettype none
// ============================================================================
// tb_reg_file_fwd : directed self-checking bench for reg_file_fwd
// Revision: 1.0
// ============================================================================
module tb_reg_file_fwd;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   reg_file_fwd_if                   bus_a ();
   reg_file_fwd_if #(.CNT_WIDTH(4))  bus_b ();

   reg_file_fwd dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
   reg_file_fwd #(.CNT_WIDTH(4)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

   task automatic idle_a();
      bus_a.reg_read_en_1 = 0;  bus_a.reg_addr_1 = '0;
      bus_a.reg_read_en_2 = 0;  bus_a.reg_addr_2 = '0;
      bus_a.ex_load_flag  = 0;  bus_a.ex_write_en = 0;
      bus_a.ex_write_addr = '0; bus_a.ex_write_data = '0;
      bus_a.mem_write_en  = 0;  bus_a.mem_write_addr = '0; bus_a.mem_write_data = '0;
      bus_a.wb_write_en   = 0;  bus_a.wb_write_addr = '0;  bus_a.wb_write_data = '0;
   endtask

   task automatic idle_b();
      bus_b.reg_read_en_1 = 0;  bus_b.reg_addr_1 = '0;
      bus_b.reg_read_en_2 = 0;  bus_b.reg_addr_2 = '0;
      bus_b.ex_load_flag  = 0;  bus_b.ex_write_en = 0;
      bus_b.ex_write_addr = '0; bus_b.ex_write_data = '0;
      bus_b.mem_write_en  = 0;  bus_b.mem_write_addr = '0; bus_b.mem_write_data = '0;
      bus_b.wb_write_en   = 0;  bus_b.wb_write_addr = '0;  bus_b.wb_write_data = '0;
   endtask

   task automatic test_reset();
      rst = 1;
      idle_a();
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd5;
      bus_a.wb_write_en = 1;   bus_a.wb_write_addr = 5'd5; bus_a.wb_write_data = 32'h55;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if (bus_a.read_data_1 !== 32'h0) begin
         errors++; $display("FAIL rst_read: got %h expected %h", bus_a.read_data_1, 32'h0);
      end
      checks++;
      if (bus_a.stall_request !== 1'b0) begin
         errors++; $display("FAIL rst_stall: got %b expected 0", bus_a.stall_request);
      end
      rst = 0;
      idle_a();
      for (int a = 0; a < 32; a++) begin
         @(negedge clk);
         bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'(a);
         bus_a.reg_read_en_2 = 1; bus_a.reg_addr_2 = 5'(31 - a);
         #1;
         checks++;
         if (bus_a.read_data_1 !== 32'h0 || bus_a.read_data_2 !== 32'h0) begin
            errors++;
            $display("FAIL rst_array a=%0d: got %h/%h expected 0/0", a,
                     bus_a.read_data_1, bus_a.read_data_2);
         end
      end
      checks++;
      if (bus_a.stall_count !== 32'd0 || bus_a.stall_request !== 1'b0) begin
         errors++; $display("FAIL rst_count: got %0d/%b expected 0/0",
                            bus_a.stall_count, bus_a.stall_request);
      end
      @(negedge clk);
      idle_a();
      bus_a.wb_write_en = 1; bus_a.wb_write_addr = 5'd0; bus_a.wb_write_data = 32'hDEADBEEF;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd0;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'h0) begin
         errors++; $display("FAIL r0_writethrough: got %h expected 0", bus_a.read_data_1);
      end
      @(negedge clk);
      bus_a.wb_write_en = 0;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'h0) begin
         errors++; $display("FAIL r0_array: got %h expected 0", bus_a.read_data_1);
      end
   endtask

   task automatic test_write_through();
      @(negedge clk);
      idle_a();
      bus_a.wb_write_en = 1; bus_a.wb_write_addr = 5'd5; bus_a.wb_write_data = 32'h12345678;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd5;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'h12345678) begin
         errors++; $display("FAIL wt_same_cycle: got %h expected %h", bus_a.read_data_1, 32'h12345678);
      end
      @(negedge clk);
      bus_a.wb_write_en = 0;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'h12345678) begin
         errors++; $display("FAIL wt_array: got %h expected %h", bus_a.read_data_1, 32'h12345678);
      end
      bus_a.reg_read_en_1 = 0;
      bus_a.reg_read_en_2 = 1; bus_a.reg_addr_2 = 5'd5;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'h0 || bus_a.read_data_2 !== 32'h12345678) begin
         errors++; $display("FAIL wt_read_en: got %h/%h expected 0/12345678",
                            bus_a.read_data_1, bus_a.read_data_2);
      end
   endtask

   task automatic test_priority();
      @(negedge clk);
      idle_a();
      bus_a.wb_write_en = 1; bus_a.wb_write_addr = 5'd8; bus_a.wb_write_data = 32'd1;
      @(negedge clk);
      bus_a.wb_write_data = 32'd2;
      bus_a.mem_write_en = 1; bus_a.mem_write_addr = 5'd8; bus_a.mem_write_data = 32'd3;
      bus_a.ex_write_en = 1;  bus_a.ex_write_addr = 5'd8;  bus_a.ex_write_data = 32'd4;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd8;
      bus_a.reg_read_en_2 = 1; bus_a.reg_addr_2 = 5'd8;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'd4 || bus_a.read_data_2 !== 32'd4) begin
         errors++; $display("FAIL prio_ex: got %h/%h expected 4/4", bus_a.read_data_1, bus_a.read_data_2);
      end
      checks++;
      if (bus_a.stall_request !== 1'b0) begin
         errors++; $display("FAIL prio_no_stall: got %b expected 0", bus_a.stall_request);
      end
      bus_a.ex_write_en = 0;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'd3) begin
         errors++; $display("FAIL prio_mem: got %h expected 3", bus_a.read_data_1);
      end
      bus_a.mem_write_en = 0;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'd2) begin
         errors++; $display("FAIL prio_wb: got %h expected 2", bus_a.read_data_1);
      end
      bus_a.wb_write_en = 0;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'd1) begin
         errors++; $display("FAIL prio_array: got %h expected 1", bus_a.read_data_1);
      end
      @(negedge clk);
      idle_a();
      bus_a.ex_write_en = 1;  bus_a.ex_write_addr = 5'd0;  bus_a.ex_write_data = 32'hFFFF;
      bus_a.mem_write_en = 1; bus_a.mem_write_addr = 5'd0; bus_a.mem_write_data = 32'hEEEE;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd0;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'h0) begin
         errors++; $display("FAIL prio_r0: got %h expected 0", bus_a.read_data_1);
      end
      idle_a();
      bus_a.mem_write_en = 1; bus_a.mem_write_addr = 5'd5; bus_a.mem_write_data = 32'h77;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd8;
      bus_a.reg_read_en_2 = 1; bus_a.reg_addr_2 = 5'd5;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'd1 || bus_a.read_data_2 !== 32'h77) begin
         errors++; $display("FAIL prio_indep: got %h/%h expected 1/77", bus_a.read_data_1, bus_a.read_data_2);
      end
   endtask

   task automatic test_load_use();
      @(negedge clk);
      idle_a();
      bus_a.ex_load_flag = 1; bus_a.ex_write_en = 1;
      bus_a.ex_write_addr = 5'd9; bus_a.ex_write_data = 32'hBAD;
      bus_a.reg_read_en_2 = 1; bus_a.reg_addr_2 = 5'd9;
      #1;
      checks++;
      if (bus_a.stall_request !== 1'b1 || bus_a.stall_count !== 32'd0) begin
         errors++; $display("FAIL lu_stall: got %b/%0d expected 1/0", bus_a.stall_request, bus_a.stall_count);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_a.stall_count !== 32'd1) begin
         errors++; $display("FAIL lu_count1: got %0d expected 1", bus_a.stall_count);
      end
      @(negedge clk);
      idle_a();
      bus_a.mem_write_en = 1; bus_a.mem_write_addr = 5'd9; bus_a.mem_write_data = 32'hAA55;
      bus_a.reg_read_en_2 = 1; bus_a.reg_addr_2 = 5'd9;
      #1;
      checks++;
      if (bus_a.read_data_2 !== 32'hAA55 || bus_a.stall_request !== 1'b0) begin
         errors++; $display("FAIL lu_mem_fwd: got %h/%b expected aa55/0", bus_a.read_data_2, bus_a.stall_request);
      end
      @(negedge clk);
      idle_a();
      bus_a.ex_load_flag = 1; bus_a.ex_write_en = 1; bus_a.ex_write_addr = 5'd9;
      bus_a.reg_read_en_2 = 0; bus_a.reg_addr_2 = 5'd9;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd3;
      #1;
      checks++;
      if (bus_a.stall_request !== 1'b0) begin
         errors++; $display("FAIL lu_read_en0: got %b expected 0", bus_a.stall_request);
      end
      bus_a.ex_write_addr = 5'd0;
      bus_a.reg_read_en_2 = 1; bus_a.reg_addr_2 = 5'd0;
      #1;
      checks++;
      if (bus_a.stall_request !== 1'b0) begin
         errors++; $display("FAIL lu_r0: got %b expected 0", bus_a.stall_request);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_a.stall_count !== 32'd1) begin
         errors++; $display("FAIL lu_count_hold: got %0d expected 1", bus_a.stall_count);
      end
      @(negedge clk);
      idle_a();
      bus_a.ex_load_flag = 1; bus_a.ex_write_en = 1; bus_a.ex_write_addr = 5'd9;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd9;
      #1;
      checks++;
      if (bus_a.stall_request !== 1'b1) begin
         errors++; $display("FAIL lu_port1: got %b expected 1", bus_a.stall_request);
      end
      @(posedge clk); #1;
      checks++;
      if (bus_a.stall_count !== 32'd2) begin
         errors++; $display("FAIL lu_count2: got %0d expected 2", bus_a.stall_count);
      end
   endtask

   task automatic test_reset_mid_stall();
      @(negedge clk);
      idle_a();
      rst = 1;
      @(negedge clk);
      rst = 0;
      bus_a.ex_load_flag = 1; bus_a.ex_write_en = 1; bus_a.ex_write_addr = 5'd9;
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd9;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (bus_a.stall_count !== 32'd3) begin
         errors++; $display("FAIL mid_count3: got %0d expected 3", bus_a.stall_count);
      end
      @(negedge clk);
      rst = 1;
      bus_a.wb_write_en = 1; bus_a.wb_write_addr = 5'd4; bus_a.wb_write_data = 32'd7;
      #1;
      checks++;
      if (bus_a.stall_request !== 1'b0 || bus_a.read_data_1 !== 32'h0) begin
         errors++; $display("FAIL mid_rst_outputs: got %b/%h expected 0/0", bus_a.stall_request, bus_a.read_data_1);
      end
      @(negedge clk);
      rst = 0;
      idle_a();
      bus_a.reg_read_en_1 = 1; bus_a.reg_addr_1 = 5'd4;
      #1;
      checks++;
      if (bus_a.read_data_1 !== 32'h0 || bus_a.stall_count !== 32'd0) begin
         errors++; $display("FAIL mid_after_rst: got %h/%0d expected 0/0", bus_a.read_data_1, bus_a.stall_count);
      end
   endtask

   task automatic test_saturation();
      int exp;
      @(negedge clk);
      idle_b();
      bus_b.ex_load_flag = 1; bus_b.ex_write_en = 1; bus_b.ex_write_addr = 5'd12;
      bus_b.reg_read_en_1 = 1; bus_b.reg_addr_1 = 5'd12;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         exp = (k < 15) ? k : 15;
         checks++;
         if (bus_b.stall_count !== 4'(exp)) begin
            errors++; $display("FAIL sat_count k=%0d: got %0d expected %0d", k, bus_b.stall_count, exp);
         end
      end
      checks++;
      if (bus_b.stall_request !== 1'b1) begin
         errors++; $display("FAIL sat_stall: got %b expected 1", bus_b.stall_request);
      end
      @(negedge clk);
      idle_b();
   endtask

   initial begin
      idle_a();
      idle_b();
      test_reset();
      test_write_through();
      test_priority();
      test_load_use();
      test_reset_mid_stall();
      test_saturation();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/reg_file_fwd.md
Name: reg_file_fwd

Overview:
- Decode-stage operand unit that consumes the decoder's read-enable/read-address and write-back pairs.
- Holds the 32-entry architectural GPR file and returns forwarded operand values with priority EX > MEM > WB > array.
- Raises a load-use stall request and keeps a saturating stall-cycle counter.
- Sits between the ID decoder and the ID/EX pipeline register.

Parameters:
- DATA_WIDTH, 32, GPR and forwarded data width.
- ADDR_WIDTH, 5, register address width.
- REG_NUM, 32, number of GPRs; entry 0 is hardwired zero.
- CNT_WIDTH, 32, width of the stall-cycle counter.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- reg_read_en_1  in  1  read port 1 enable
- reg_addr_1  in  ADDR_WIDTH  read port 1 address
- reg_read_en_2  in  1  read port 2 enable
- reg_addr_2  in  ADDR_WIDTH  read port 2 address
- ex_load_flag  in  1  instruction in EX is a load (LB/LBU/LH/LHU/LW)
- ex_write_en  in  1  EX result write enable
- ex_write_addr  in  ADDR_WIDTH  EX destination
- ex_write_data  in  DATA_WIDTH  EX result
- mem_write_en  in  1  MEM write enable
- mem_write_addr  in  ADDR_WIDTH  MEM destination
- mem_write_data  in  DATA_WIDTH  MEM result
- wb_write_en  in  1  WB commit enable
- wb_write_addr  in  ADDR_WIDTH  WB destination
- wb_write_data  in  DATA_WIDTH  WB data
- read_data_1  out  DATA_WIDTH  forwarded operand 1
- read_data_2  out  DATA_WIDTH  forwarded operand 2
- stall_request  out  1  load-use hazard; freeze PC/IF/ID, bubble into EX
- stall_count  out  CNT_WIDTH  cycles with stall_request=1 since reset

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset: on the rising edge with rst=1, all REG_NUM entries are cleared to 0 and stall_count is cleared to 0. While rst=1, read_data_1/2=0 and stall_request=0. A WB write in the same cycle as rst is dropped; rst wins.
- Write: on the rising edge with wb_write_en=1 and wb_write_addr!=0, the entry is updated. Writes to address 0 are ignored; entry 0 always reads 0.
- Read, per port n (combinational, zero latency):
  - read_en_n=0 -> 0.
  - addr_n==0 -> 0, with no forwarding even if a stage targets $0.
  - else ex_write_en && ex_write_addr==addr_n && !ex_load_flag -> ex_write_data.
  - else mem_write_en && mem_write_addr==addr_n -> mem_write_data.
  - else wb_write_en && wb_write_addr==addr_n -> wb_write_data (same-cycle write-through).
  - else array[addr_n].
- Load-use: stall_request=1 iff ex_load_flag && ex_write_en && ex_write_addr!=0 and, for any port n, read_en_n && addr_n==ex_write_addr.
  - During a stall the operand value from the matched EX load is not used (it is not forwarded); the read falls through to MEM/WB/array and is don't-care to the consumer.
  - Stall lasts exactly while the condition holds, normally 1 cycle: the next cycle the load is in MEM and the operand is forwarded from MEM.
- stall_count: increments by 1 on each rising edge where stall_request=1 and rst=0. It saturates at all-ones and does not wrap.
- Simultaneous EX, MEM and WB hits on the same address: EX wins, else MEM, else WB. Both ports resolve independently; both may hit the same stage.

Test Plan:
- Reset and $0: rst=1 for 2 cycles, then read both ports at addr 0..31 -> all 0, stall_request=0, stall_count=0. Write wb addr 0 data 0xDEADBEEF, then read addr 0 -> 0.
- Write/readback with write-through: WB write r5=0x12345678, port 1 reads r5 in the same cycle -> 0x12345678. Next cycle, with WB idle -> 0x12345678 from the array.
- Forward priority: r8 in array =1, wb r8=2, mem r8=3, ex r8=4 (non-load).
  - Port 1 reads r8 -> 4.
  - Drop EX -> 3.
  - Drop MEM -> 2.
  - Drop WB -> 1.
- Load-use: ex_load_flag=1, ex_write_addr=9, port 2 reads r9.
  - -> stall_request=1 for 1 cycle, stall_count 0->1.
  - Next cycle, mem r9=0xAA55 -> read_data_2=0xAA55, stall_request=0.
  - Same stimulus with read_en_2=0, or with ex_write_addr=0 -> no stall.
- Reset mid-stall: hold the load-use condition 3 cycles (stall_count=3), assert rst with a pending WB write r4=7. After the edge -> stall_count=0, r4 reads 0.
- Saturation (CNT_WIDTH overridden to 4): hold the stall 20 cycles -> stall_count=15, stays 15.
